// File: rtl/int_to_fp_converter_if.sv
// int_to_fp_converter_if: stream handshake and result bundle between integer source and converter.
interface int_to_fp_converter_if #(
  parameter int INT_W = 16,
  parameter int EXP_W = 4,
  parameter int SIG_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [INT_W-1:0]         in_int;
  logic                     out_valid;
  logic                     out_ready;
  logic [EXP_W+SIG_W:0]     result;
  logic                     inexact;
  logic                     busy;
  modport master (output in_valid, in_int, out_ready, input in_ready, out_valid, result, inexact, busy);
  modport slave  (input in_valid, in_int, out_ready, output in_ready, out_valid, result, inexact, busy);
endinterface

// File: rtl/int_to_fp_converter.sv
// int_to_fp_converter: signed integer to {sign, exp, sig} operand, one normalizing right shift per cycle.
module int_to_fp_converter #(
  parameter int INT_W = 16,
  parameter int EXP_W = 4,
  parameter int SIG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  int_to_fp_converter_if.slave io
);
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t                state_q, state_d;
  logic                  sign_q, sign_d;
  logic [INT_W-1:0]      mag_q, mag_d;
  logic [EXP_W-1:0]      exp_q, exp_d;
  logic                  sticky_q, sticky_d;
  logic [EXP_W+SIG_W:0]  result_q, result_d;
  logic                  inexact_q, inexact_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      exp_q     <= '0;
      sticky_q  <= 1'b0;
      result_q  <= '0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      sticky_q  <= sticky_d;
      result_q  <= result_d;
      inexact_q <= inexact_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    sticky_d  = sticky_q;
    result_d  = result_q;
    inexact_d = inexact_q;
    case (state_q)
      IDLE: if (io.in_valid) begin
        sign_d   = io.in_int[INT_W-1];
        mag_d    = io.in_int[INT_W-1] ? -io.in_int : io.in_int;
        exp_d    = '0;
        sticky_d = 1'b0;
        state_d  = NORM;
      end
      NORM: if (|mag_q[INT_W-1:SIG_W]) begin
        mag_d    = mag_q >> 1;
        sticky_d = sticky_q | mag_q[0];
        exp_d    = exp_q + EXP_W'(1);
      end else begin
        result_d  = {sign_q, exp_q, mag_q[SIG_W-1:0]};
        inexact_d = sticky_q;
        state_d   = DONE;
      end
      DONE: state_d = io.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign io.in_ready  = state_q == IDLE;
  assign io.out_valid = state_q == DONE;
  assign io.busy      = state_q != IDLE;
  assign io.result    = result_q;
  assign io.inexact   = inexact_q;
endmodule

// File: tb/tb_int_to_fp_converter.sv
// tb_int_to_fp_converter: random and directed conversions against an arithmetic reference model.
module tb_int_to_fp_converter;
  localparam int INT_W = 16, EXP_W = 4, SIG_W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0;
  int_to_fp_converter_if #(.INT_W(INT_W), .EXP_W(EXP_W), .SIG_W(SIG_W)) io ();
  int_to_fp_converter #(.INT_W(INT_W), .EXP_W(EXP_W), .SIG_W(SIG_W)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic model(input int x, output logic [12:0] r, output logic ix, output int k);
    int m, bl;
    m  = x < 0 ? -x : x;
    bl = $clog2(m + 1);
    k  = bl > SIG_W ? bl - SIG_W : 0;
    r  = {x < 0, 4'(k), 8'(m / (1 << k))};
    ix = (m % (1 << k)) != 0;
  endtask
  task automatic convert(input logic signed [15:0] x, input int hold);
    logic [12:0] er, r0;
    logic ei;
    int k, n;
    model(int'(x), er, ei, k);
    io.in_valid = 1'b1;
    io.in_int   = x;
    @(posedge clk); #1;
    n = 0;
    do begin
      io.in_valid = 1'($urandom);
      io.in_int   = 16'($urandom);
      @(posedge clk); #1;
      n++;
    end while (!io.out_valid && n < 40);
    chk("latency", n, k + 1);
    chk("result", io.result, er);
    chk("inexact", io.inexact, ei);
    chk("in_ready_done", io.in_ready, 0);
    r0 = io.result;
    for (int i = 0; i < hold; i++) begin
      io.in_valid = 1'($urandom);
      io.in_int   = 16'($urandom);
      @(posedge clk); #1;
      chk("hold_result", io.result, r0);
      chk("hold_valid", io.out_valid, 1);
      chk("hold_in_ready", io.in_ready, 0);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    chk("drop_valid", io.out_valid, 0);
    chk("idle_ready", io.in_ready, 1);
    chk("idle_busy", io.busy, 0);
  endtask
  initial begin
    io.in_valid  = 1'b0;
    io.in_int    = '0;
    io.out_ready = 1'b0;
    #12;
    chk("rst_result", io.result, 0);
    chk("rst_valid", io.out_valid, 0);
    chk("rst_ready", io.in_ready, 1);
    chk("rst_busy", io.busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    convert(16'sd5, 0);
    convert(16'sd300, 0);
    convert(16'sd1023, 0);
    convert(-16'sd200, 0);
    convert(-16'sd32768, 0);
    convert(16'sd0, 0);
    convert(16'sd255, 0);
    convert(16'sd256, 0);
    convert(16'sd32767, 10);
    convert(16'sd9, 0);
    io.in_valid = 1'b1;
    io.in_int   = -16'sd32768;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_result", io.result, 0);
    chk("midrst_inexact", io.inexact, 0);
    chk("midrst_valid", io.out_valid, 0);
    chk("midrst_ready", io.in_ready, 1);
    chk("midrst_busy", io.busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    convert(16'sd7, 0);
    for (int i = 0; i < 40; i++) convert(16'($urandom), int'($urandom_range(0, 3)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
